convolution_engine: RTL
=======================

// Module: convolution_engine
// PURPOSE
//  Consumer side of the kernel-coefficient interface: applies a 3x3 signed kernel plus right-shift
//  to a streamed 3x3 window of 8-bit unsigned tactile/image pixels. Sits between the line-buffer
//  window generator and the display/threshold path, fed by a coefficient source such as kernels.
//  Coefficients are double-buffered so a kernel change takes effect only at a frame boundary.
// PARAMETERS
//  ABS_OUT    0   1: output |result| (edge kernels); 0: negative results clamp to 0
//  HCOUNT_W   11  width of hcount sideband
//  VCOUNT_W   10  width of vcount sideband
//  SAT_CNT_W  16  width of saturation-event counter
// PORTS
//  clk_in          in   1         system clock
//  rst_n_in        in   1         asynchronous, active-low reset
//  coeffs_in       in   [2:0][2:0][7:0] signed  kernel, [row][col], same packing as kernels.coeffs
//  shift_in        in   8 signed  right-shift amount paired with coeffs_in
//  coeff_load_in   in   1         strobe: capture coeffs_in/shift_in into shadow registers
//  window_in       in   [2:0][2:0][7:0] unsigned pixel window, [row][col], [1][1] = centre
//  valid_in        in   1         window_in and sideband valid this cycle
//  frame_start_in  in   1         qualifies first window of a frame (ignored unless valid_in)
//  hcount_in       in   HCOUNT_W  pixel column sideband
//  vcount_in       in   VCOUNT_W  pixel row sideband
//  pixel_out       out  8         filtered pixel
//  valid_out       out  1         pixel_out valid
//  frame_start_out out  1         frame_start delayed to match pixel_out
//  hcount_out      out  HCOUNT_W  hcount delayed to match
//  vcount_out      out  VCOUNT_W  vcount delayed to match
//  sat_count_out   out  SAT_CNT_W saturation events in current frame
// BEHAVIOUR
//  Reset (async assert, sync-released by top): all outputs 0; shadow and active kernel = identity
//   ([1][1]=1, others 0, shift 0); pipeline valids 0; sat counter 0.
//  Coefficient path: coeff_load_in=1 -> shadow <= {coeffs_in, shift_in} next edge. Active <= shadow
//   on valid_in & frame_start_in; that first window already uses the new shadow value (bypass).
//   coeff_load_in coincident with frame_start: shadow receives new value, frame uses OLD shadow.
//  Shift clamp: shift<0 -> 0; shift>15 -> 15; clamp applied when copying into active.
//  Pipeline, fixed latency 3 cycles, no backpressure, one window per cycle accepted:
//   S1: 9 products, 8u x 8s -> 17-bit signed each (pixel zero-extended to 9 bits signed).
//   S2: adder tree, 21-bit signed sum (no overflow possible: max |sum| = 9*255*128).
//   S3: arithmetic shift right by active shift (floor toward -inf); ABS_OUT applied; saturate to
//       [0,255]; register to pixel_out.
//  Sideband (valid, frame_start, hcount, vcount) delayed by exactly 3 registers alongside data.
//  valid_out=0 cycles: pixel_out holds last value; sideband registers still shift (valid gates use).
//  Saturation counter: +1 each valid S3 result clipped (>255, or <0 when ABS_OUT=0);
//   holds at all-ones (no wrap); cleared to 0 (or 1 if that result saturates) on valid frame_start at S3.
//  Bubbles (valid_in=0) propagate; frame_start without valid_in ignored entirely.
//  Reset mid-stream: in-flight windows discarded, valid_out=0 next cycle, kernel returns to identity.
// TESTING
//  1 Reset, no load, window all 100, valid 1 cycle -> valid_out high exactly 3 cycles later, pixel_out=100.
//  2 Load Gaussian(1,2,1/2,4,2/1,2,1, shift 4), frame_start; window all 200 -> pixel_out=200, sat_count 0.
//  3 Load Sobel-X mid-frame, then non-frame_start windows -> still Gaussian; next frame_start window
//    with left col 255, rest 0 -> pixel_out=255 (1020 clipped), sat_count_out=1.
//  4 Sobel-X, ABS_OUT=0, right col 255, rest 0 -> pixel_out=0, sat counted; ABS_OUT=1 -> 255.
//  5 shift_in=-3 and shift_in=40 with identity x8 centre 10 -> outputs 80 and 0 (shift 15).
//  6 Back-to-back windows with bubbles and hcount 0..5, assert rst_n_in low mid-burst ->
//    sideband aligned to data, valid_out 0 after reset, next output uses identity kernel.

Source files
------------

// File: rtl/convolution_engine.sv
// convolution_engine: 3x3 signed kernel + arithmetic right shift over a streamed
// 8-bit unsigned pixel window. Coefficients are double-buffered (shadow/active);
// a new kernel becomes active on the first valid window of a frame.
// Fixed 3-cycle latency: S1 products, S2 adder tree, S3 shift/abs/saturate.

// One kernel tap: unsigned pixel times signed coefficient, 17-bit signed product.
module conv_tap (
  input  logic [7:0]  pix_in,
  input  logic [7:0]  coef_in,
  output logic [16:0] prod_out
);
  logic signed [16:0] pix_s, coef_s, prod_s;
  assign pix_s    = $signed({9'd0, pix_in});
  assign coef_s   = $signed({{9{coef_in[7]}}, coef_in});
  assign prod_s   = pix_s * coef_s;
  assign prod_out = prod_s;
endmodule

module convolution_engine #(
  parameter int ABS_OUT   = 0,
  parameter int HCOUNT_W  = 11,
  parameter int VCOUNT_W  = 10,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [2:0][2:0][7:0] coeffs_in,
  input  logic [7:0]           shift_in,
  input  logic                 coeff_load_in,
  input  logic [2:0][2:0][7:0] window_in,
  input  logic                 valid_in,
  input  logic                 frame_start_in,
  input  logic [HCOUNT_W-1:0]  hcount_in,
  input  logic [VCOUNT_W-1:0]  vcount_in,
  output logic [7:0]           pixel_out,
  output logic                 valid_out,
  output logic                 frame_start_out,
  output logic [HCOUNT_W-1:0]  hcount_out,
  output logic [VCOUNT_W-1:0]  vcount_out,
  output logic [SAT_CNT_W-1:0] sat_count_out
);
  localparam int          STAGES  = 3;
  // Identity kernel: only the centre tap ([1][1], flat index 4) is 1.
  localparam logic [71:0] IDENT_K = 72'h1 << 32;

  // Shift amounts are 8-bit signed; the active copy is clamped to 0..15.
  function automatic logic [3:0] clamp_shift(input logic [7:0] s);
    logic [3:0] r;
    if (s[7])            r = 4'd0;
    else if (s > 8'd15)  r = 4'd15;
    else                 r = s[3:0];
    return r;
  endfunction

  logic [71:0]        shadow_k_q, shadow_k_d, act_k_q, act_k_d;
  logic [7:0]         shadow_s_q, shadow_s_d;
  logic [3:0]         act_s_q, act_s_d;
  logic               frame_take;
  logic [8:0][7:0]    kern, pix;
  logic [3:0]         kern_shift;
  logic [8:0][16:0]   prod, prod_q, prod_d;
  logic [3:0]         s1_shift_q, s1_shift_d, s2_shift_q, s2_shift_d;
  logic signed [20:0] sum_q, sum_d, shifted, mag;
  logic [7:0]         clip, pix_q, pix_d;
  logic               sat;
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic [STAGES:1]    vld_pipe_q, vld_pipe_d, fs_pipe_q, fs_pipe_d;
  logic [STAGES:1][HCOUNT_W-1:0] hc_pipe_q, hc_pipe_d;
  logic [STAGES:1][VCOUNT_W-1:0] vc_pipe_q, vc_pipe_d;

  // Kernel select: the frame-start window bypasses straight from the shadow copy.
  always_comb begin
    frame_take = valid_in & frame_start_in;
    kern       = frame_take ? shadow_k_q : act_k_q;
    kern_shift = frame_take ? clamp_shift(shadow_s_q) : act_s_q;
    pix        = window_in;
  end

  for (genvar i = 0; i < 9; i++) begin : g_tap
    conv_tap u_tap (.pix_in(pix[i]), .coef_in(kern[i]), .prod_out(prod[i]));
  end

  // Next-state for coefficient buffers, datapath stages and sideband shift registers.
  always_comb begin
    shadow_k_d = shadow_k_q;
    shadow_s_d = shadow_s_q;
    if (coeff_load_in) begin
      shadow_k_d = coeffs_in;
      shadow_s_d = shift_in;
    end
    act_k_d = act_k_q;
    act_s_d = act_s_q;
    if (frame_take) begin
      act_k_d = shadow_k_q;
      act_s_d = clamp_shift(shadow_s_q);
    end

    prod_d     = prod;
    s1_shift_d = kern_shift;

    sum_d = '0;
    for (int i = 0; i < 9; i++) sum_d = sum_d + 21'($signed(prod_q[i]));
    s2_shift_d = s1_shift_q;

    // S3: floor shift, optional magnitude, clip to a byte.
    shifted = sum_q >>> s2_shift_q;
    mag     = ((ABS_OUT != 0) && (shifted < 0)) ? -shifted : shifted;
    sat     = 1'b0;
    clip    = mag[7:0];
    if (mag > 21'sd255) begin
      clip = 8'hFF;
      sat  = 1'b1;
    end else if (mag < 21'sd0) begin
      clip = 8'h00;
      sat  = 1'b1;
    end
    pix_d = vld_pipe_q[STAGES-1] ? clip : pix_q;

    // Per-frame saturation count, sticky at all-ones.
    sat_cnt_d = sat_cnt_q;
    if (vld_pipe_q[STAGES-1]) begin
      if (fs_pipe_q[STAGES-1])            sat_cnt_d = {{(SAT_CNT_W-1){1'b0}}, sat};
      else if (sat && !(&sat_cnt_q))      sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
    end

    vld_pipe_d = {vld_pipe_q[STAGES-1:1], valid_in};
    fs_pipe_d  = {fs_pipe_q[STAGES-1:1], frame_take};
    hc_pipe_d  = {hc_pipe_q[STAGES-1:1], hcount_in};
    vc_pipe_d  = {vc_pipe_q[STAGES-1:1], vcount_in};
  end

  // State registers; reset drops in-flight windows and restores the identity kernel.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shadow_k_q <= IDENT_K;
      shadow_s_q <= '0;
      act_k_q    <= IDENT_K;
      act_s_q    <= '0;
      prod_q     <= '0;
      s1_shift_q <= '0;
      sum_q      <= '0;
      s2_shift_q <= '0;
      pix_q      <= '0;
      sat_cnt_q  <= '0;
      vld_pipe_q <= '0;
      fs_pipe_q  <= '0;
      hc_pipe_q  <= '0;
      vc_pipe_q  <= '0;
    end else begin
      shadow_k_q <= shadow_k_d;
      shadow_s_q <= shadow_s_d;
      act_k_q    <= act_k_d;
      act_s_q    <= act_s_d;
      prod_q     <= prod_d;
      s1_shift_q <= s1_shift_d;
      sum_q      <= sum_d;
      s2_shift_q <= s2_shift_d;
      pix_q      <= pix_d;
      sat_cnt_q  <= sat_cnt_d;
      vld_pipe_q <= vld_pipe_d;
      fs_pipe_q  <= fs_pipe_d;
      hc_pipe_q  <= hc_pipe_d;
      vc_pipe_q  <= vc_pipe_d;
    end
  end

  assign pixel_out       = pix_q;
  assign valid_out       = vld_pipe_q[STAGES];
  assign frame_start_out = fs_pipe_q[STAGES];
  assign hcount_out      = hc_pipe_q[STAGES];
  assign vcount_out      = vc_pipe_q[STAGES];
  assign sat_count_out   = sat_cnt_q;
endmodule
